// File: rtl/parking_pkg.sv
// Shared definitions for the parking entry gate and the occupancy counter it feeds.
// Capacities live here so both sides of the car-entry interface agree on them.
package parking_pkg;

    localparam int unsigned UNI_CAPACITY     = 500;
    localparam int unsigned FREE_CAPACITY    = 200;
    localparam int unsigned TOTAL_CAPACITY   = UNI_CAPACITY + FREE_CAPACITY;
    localparam int unsigned ENTRY_PULSE_LEN  = 2;
    localparam int unsigned REJECT_LEN_DEF   = 4;
    localparam int unsigned OPEN_TIMEOUT_DEF = 1000;

    typedef enum logic [2:0] {
        GATE_IDLE,
        GATE_CHECK,
        GATE_OPEN,
        GATE_SETUP,
        GATE_PULSE,
        GATE_HOLD,
        GATE_REJECT
    } gate_state_e;

    typedef struct packed {
        logic barrier_open;
        logic car_entered;
        logic is_uni_car_entered;
        logic reject;
        logic timeout;
        logic overflow_err;
    } gate_out_t;

    // Counter width that never collapses to zero bits for tiny limits.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/parking_entry_gate_if.sv
// Entry-gate bus: sensors and counter flags in, barrier command and car-entry event out.
interface parking_entry_gate_if;

    logic car_at_gate;
    logic card_valid;
    logic card_is_uni;
    logic car_passed;
    logic uni_is_vacated_space;
    logic free_is_vacated_space;
    logic ja_nist;

    logic barrier_open;
    logic car_entered;
    logic is_uni_car_entered;
    logic reject;
    logic timeout;
    logic overflow_err;

    modport master (
        input  car_at_gate, card_valid, card_is_uni, car_passed,
               uni_is_vacated_space, free_is_vacated_space, ja_nist,
        output barrier_open, car_entered, is_uni_car_entered, reject,
               timeout, overflow_err
    );

    modport slave (
        output car_at_gate, card_valid, card_is_uni, car_passed,
               uni_is_vacated_space, free_is_vacated_space, ja_nist,
        input  barrier_open, car_entered, is_uni_car_entered, reject,
               timeout, overflow_err
    );

endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector for a synchronous level sensor; one history register.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_c_o
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_c_o = sig_i & ~sig_q;

endmodule

// File: rtl/parking_entry_gate.sv
// Entry-gate controller: admits a car on card + vacancy, opens the barrier and
// emits one car_entered pulse with a type qualifier that is stable around both edges.
module parking_entry_gate
    import parking_pkg::*;
#(
    parameter int unsigned OPEN_TIMEOUT = OPEN_TIMEOUT_DEF,
    parameter int unsigned PULSE_LEN    = ENTRY_PULSE_LEN,
    parameter int unsigned REJECT_LEN   = REJECT_LEN_DEF,
    parameter bit          UNI_FALLBACK = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    parking_entry_gate_if.master bus
);

    localparam int unsigned TW      = clog2_min1(OPEN_TIMEOUT);
    localparam int unsigned CNT_MAX = (PULSE_LEN > REJECT_LEN) ? PULSE_LEN : REJECT_LEN;
    localparam int unsigned CW      = clog2_min1(CNT_MAX);

    gate_state_e    state_q, state_d;
    logic           type_q, type_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           uni_vac_q, free_vac_q;
    gate_out_t      out_q, out_d;
    logic           pass_rise_c;

    edge_detect u_pass_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .sig_i    (bus.car_passed),
        .rise_c_o (pass_rise_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= GATE_IDLE;
            type_q     <= 1'b0;
            timer_q    <= '0;
            cnt_q      <= '0;
            uni_vac_q  <= 1'b0;
            free_vac_q <= 1'b0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            uni_vac_q  <= bus.uni_is_vacated_space;
            free_vac_q <= bus.free_is_vacated_space;
            out_q      <= out_d;
        end
    end

    // Next state plus registered outputs decoded from the state being entered.
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        timer_d = '0;
        cnt_d   = '0;
        out_d   = '0;

        unique case (state_q)
            GATE_IDLE: begin
                if (bus.card_valid && bus.car_at_gate) begin
                    type_d  = bus.card_is_uni;
                    state_d = GATE_CHECK;
                end
            end
            GATE_CHECK: begin
                if (type_q && uni_vac_q) begin
                    state_d = GATE_OPEN;
                end else if (type_q && UNI_FALLBACK && free_vac_q) begin
                    type_d  = 1'b0;
                    state_d = GATE_OPEN;
                end else if (!type_q && free_vac_q) begin
                    state_d = GATE_OPEN;
                end else begin
                    state_d = GATE_REJECT;
                end
            end
            GATE_OPEN: begin
                // A passage edge in the last open cycle still counts as an entry.
                if (pass_rise_c) begin
                    state_d = GATE_SETUP;
                end else if (timer_q == TW'(OPEN_TIMEOUT - 1)) begin
                    state_d       = GATE_IDLE;
                    out_d.timeout = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            GATE_SETUP: begin
                state_d = GATE_PULSE;
            end
            GATE_PULSE: begin
                if (cnt_q == CW'(PULSE_LEN - 1)) begin
                    state_d = GATE_HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GATE_HOLD: begin
                state_d = GATE_IDLE;
            end
            GATE_REJECT: begin
                if (cnt_q == CW'(REJECT_LEN - 1)) begin
                    state_d = GATE_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = GATE_IDLE;
            end
        endcase

        out_d.barrier_open       = (state_d == GATE_OPEN);
        out_d.car_entered        = (state_d == GATE_PULSE);
        out_d.is_uni_car_entered = type_d && (state_d inside {GATE_SETUP, GATE_PULSE, GATE_HOLD});
        out_d.reject             = (state_d == GATE_REJECT);
        out_d.overflow_err       = (state_d == GATE_HOLD) && bus.ja_nist;
    end

    assign bus.barrier_open       = out_q.barrier_open;
    assign bus.car_entered        = out_q.car_entered;
    assign bus.is_uni_car_entered = out_q.is_uni_car_entered;
    assign bus.reject             = out_q.reject;
    assign bus.timeout            = out_q.timeout;
    assign bus.overflow_err       = out_q.overflow_err;

endmodule

// File: tb/tb_parking_entry_gate.sv
// Bench for parking_entry_gate: two instances (fallback on/off) against a timeline model.
module tb_parking_entry_gate;

    localparam int T = 20;
    localparam int L = 2;
    localparam int R = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    parking_entry_gate_if bus_a ();
    parking_entry_gate_if bus_b ();

    assign bus_b.car_at_gate           = bus_a.car_at_gate;
    assign bus_b.card_valid            = bus_a.card_valid;
    assign bus_b.card_is_uni           = bus_a.card_is_uni;
    assign bus_b.car_passed            = bus_a.car_passed;
    assign bus_b.uni_is_vacated_space  = bus_a.uni_is_vacated_space;
    assign bus_b.free_is_vacated_space = bus_a.free_is_vacated_space;
    assign bus_b.ja_nist               = bus_a.ja_nist;

    parking_entry_gate #(.OPEN_TIMEOUT(T), .PULSE_LEN(L), .REJECT_LEN(R), .UNI_FALLBACK(1'b1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    parking_entry_gate #(.OPEN_TIMEOUT(T), .PULSE_LEN(L), .REJECT_LEN(R), .UNI_FALLBACK(1'b0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic [5:0] act_a, act_b;
    assign act_a = {bus_a.barrier_open, bus_a.car_entered, bus_a.is_uni_car_entered,
                    bus_a.reject, bus_a.timeout, bus_a.overflow_err};
    assign act_b = {bus_b.barrier_open, bus_b.car_entered, bus_b.is_uni_car_entered,
                    bus_b.reject, bus_b.timeout, bus_b.overflow_err};

    int n_chk  = 0;
    int n_pass = 0;

    // Model: each transaction is an acceptance edge plus an optional passage edge.
    int  k = 0;
    int  acc[2], pass_e[2], free_at[2];
    bit  adm[2], uni_t[2], has_pass[2], ovf_v[2];
    bit  cp_prev;

    int cnt_bar, cnt_ce, cnt_uni, cnt_rej, cnt_to, cnt_ovf, cnt_rej_b;

    initial begin
        forever begin
            bit rise;
            @(posedge clk);
            k = k + 1;
            rise = bus_a.car_passed && !cp_prev;
            cp_prev = bus_a.car_passed;
            if (!rst_n) begin
                cp_prev = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    acc[i] = -1000; pass_e[i] = 0; free_at[i] = 0;
                    adm[i] = 1'b0; uni_t[i] = 1'b0; has_pass[i] = 1'b0; ovf_v[i] = 1'b0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (adm[i] && !has_pass[i] && rise && k >= acc[i] + 2 && k <= acc[i] + 1 + T) begin
                        has_pass[i] = 1'b1;
                        pass_e[i]   = k;
                        free_at[i]  = k + L + 3;
                    end
                    if (has_pass[i] && k == pass_e[i] + L + 1)
                        ovf_v[i] = bus_a.ja_nist;
                    if (k >= free_at[i] && bus_a.card_valid && bus_a.car_at_gate) begin
                        acc[i] = k; has_pass[i] = 1'b0; ovf_v[i] = 1'b0;
                        if (bus_a.card_is_uni && bus_a.uni_is_vacated_space) begin
                            adm[i] = 1'b1; uni_t[i] = 1'b1;
                        end else if (bus_a.card_is_uni && i == 0 && bus_a.free_is_vacated_space) begin
                            adm[i] = 1'b1; uni_t[i] = 1'b0;
                        end else if (!bus_a.card_is_uni && bus_a.free_is_vacated_space) begin
                            adm[i] = 1'b1; uni_t[i] = 1'b0;
                        end else begin
                            adm[i] = 1'b0; uni_t[i] = 1'b0;
                        end
                        free_at[i] = adm[i] ? k + T + 2 : k + R + 2;
                    end
                end
            end
        end
    end

    function automatic logic [5:0] model_out(input int i);
        logic bar, ce, uni, rej, to, ovf;
        if (!rst_n) return 6'b0;
        bar = adm[i] && k >= acc[i] + 1 && (has_pass[i] ? k < pass_e[i] : k <= acc[i] + T);
        to  = adm[i] && !has_pass[i] && k == acc[i] + 1 + T;
        rej = !adm[i] && k >= acc[i] + 1 && k <= acc[i] + R;
        ce  = has_pass[i] && k >= pass_e[i] + 1 && k <= pass_e[i] + L;
        uni = has_pass[i] && uni_t[i] && k >= pass_e[i] && k <= pass_e[i] + L + 1;
        ovf = has_pass[i] && k == pass_e[i] + L + 1 && ovf_v[i];
        return {bar, ce, uni, rej, to, ovf};
    endfunction

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d cycle %0d: got %b expected %b", name, idx, k, act, exp);
    endtask

    task automatic expect_eq(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Per-cycle comparison of both instances against the model, away from the active edge.
    initial begin
        string nm[6];
        nm = '{"barrier_open", "car_entered", "is_uni_car_entered", "reject", "timeout", "overflow_err"};
        forever begin
            logic [5:0] e, a;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                e = model_out(i);
                a = (i == 0) ? act_a : act_b;
                for (int j = 0; j < 6; j++) chk(nm[j], i, a[5-j], e[5-j]);
            end
            cnt_bar   += int'(act_a[5]);
            cnt_ce    += int'(act_a[4]);
            cnt_uni   += int'(act_a[3]);
            cnt_rej   += int'(act_a[2]);
            cnt_to    += int'(act_a[1]);
            cnt_ovf   += int'(act_a[0]);
            cnt_rej_b += int'(act_b[2]);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_cnt();
        cnt_bar = 0; cnt_ce = 0; cnt_uni = 0; cnt_rej = 0; cnt_to = 0; cnt_ovf = 0; cnt_rej_b = 0;
    endtask

    task automatic card(input bit uni, input bit at_gate);
        bus_a.card_valid  = 1'b1;
        bus_a.card_is_uni = uni;
        bus_a.car_at_gate = at_gate;
        step(1);
        bus_a.card_valid  = 1'b0;
    endtask

    initial begin
        bus_a.car_at_gate = 1'b0; bus_a.card_valid = 1'b0; bus_a.card_is_uni = 1'b0;
        bus_a.car_passed = 1'b0; bus_a.uni_is_vacated_space = 1'b1;
        bus_a.free_is_vacated_space = 1'b1; bus_a.ja_nist = 1'b0;
        clear_cnt();
        step(3);
        expect_eq("reset_outputs_a", int'(act_a), 0);
        expect_eq("reset_outputs_b", int'(act_b), 0);
        rst_n = 1'b1;
        step(2);

        // Card without a car in front of the gate is ignored.
        clear_cnt();
        card(1'b1, 1'b0);
        step(6);
        expect_eq("no_car_barrier", cnt_bar, 0);
        expect_eq("no_car_reject", cnt_rej, 0);

        // Uni admit, a second card while open is ignored, passage 10 cycles after the card.
        clear_cnt();
        card(1'b1, 1'b1);
        step(3);
        card(1'b0, 1'b1);
        step(5);
        bus_a.car_passed = 1'b1;
        step(1); bus_a.car_at_gate = 1'b0;
        step(2); bus_a.car_passed = 1'b0;
        step(10);
        expect_eq("uni_barrier_cycles", cnt_bar, 9);
        expect_eq("uni_car_entered_cycles", cnt_ce, 2);
        expect_eq("uni_qualifier_cycles", cnt_uni, 4);
        expect_eq("uni_timeout", cnt_to, 0);

        // Free card with no free space is rejected.
        clear_cnt();
        bus_a.free_is_vacated_space = 1'b0;
        card(1'b0, 1'b1);
        step(8);
        expect_eq("reject_cycles", cnt_rej, 4);
        expect_eq("reject_barrier", cnt_bar, 0);
        expect_eq("reject_car_entered", cnt_ce, 0);

        // Uni full, free available: fallback instance admits as free, other rejects.
        clear_cnt();
        bus_a.uni_is_vacated_space = 1'b0; bus_a.free_is_vacated_space = 1'b1;
        card(1'b1, 1'b1);
        step(4);
        bus_a.car_passed = 1'b1;
        step(2); bus_a.car_passed = 1'b0;
        step(10);
        expect_eq("fallback_car_entered", cnt_ce, 2);
        expect_eq("fallback_qualifier", cnt_uni, 0);
        expect_eq("fallback_barrier", cnt_bar, 4);
        expect_eq("no_fallback_reject", cnt_rej_b, 4);

        // No passage: barrier open OPEN_TIMEOUT cycles, then a single timeout pulse.
        clear_cnt();
        bus_a.uni_is_vacated_space = 1'b1;
        card(1'b1, 1'b1);
        step(26);
        expect_eq("timeout_barrier", cnt_bar, 20);
        expect_eq("timeout_pulse", cnt_to, 1);
        expect_eq("timeout_car_entered", cnt_ce, 0);

        // Sensor already high at opening must fall and rise again before the event.
        bus_a.car_passed = 1'b1;
        step(2);
        clear_cnt();
        card(1'b1, 1'b1);
        step(4); bus_a.car_passed = 1'b0;
        step(3); bus_a.car_passed = 1'b1;
        step(2); bus_a.car_passed = 1'b0;
        step(10);
        expect_eq("prehigh_barrier", cnt_bar, 7);
        expect_eq("prehigh_car_entered", cnt_ce, 2);
        expect_eq("prehigh_timeout", cnt_to, 0);

        // Passage edge in the final open cycle wins over the timeout.
        clear_cnt();
        card(1'b1, 1'b1);
        step(20); bus_a.car_passed = 1'b1;
        step(2);  bus_a.car_passed = 1'b0;
        step(10);
        expect_eq("edge_at_limit_barrier", cnt_bar, 20);
        expect_eq("edge_at_limit_car_entered", cnt_ce, 2);
        expect_eq("edge_at_limit_timeout", cnt_to, 0);

        // Reset asserted in the middle of the entry pulse clears outputs at once.
        card(1'b1, 1'b1);
        step(3); bus_a.car_passed = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_eq("pulse_before_reset", int'(bus_a.car_entered), 1);
        expect_eq("qualifier_before_reset", int'(bus_a.is_uni_car_entered), 1);
        #1 rst_n = 1'b0;
        #1;
        expect_eq("reset_car_entered", int'(bus_a.car_entered), 0);
        expect_eq("reset_qualifier", int'(bus_a.is_uni_car_entered), 0);
        expect_eq("reset_barrier", int'(bus_a.barrier_open), 0);
        step(2);
        rst_n = 1'b1; bus_a.car_passed = 1'b0;
        step(2);

        // Counter overflow flag during the hold cycle gives one overflow_err pulse.
        clear_cnt();
        bus_a.ja_nist = 1'b1;
        card(1'b1, 1'b1);
        step(3); bus_a.car_passed = 1'b1;
        step(2); bus_a.car_passed = 1'b0;
        step(8);
        bus_a.ja_nist = 1'b0;
        expect_eq("overflow_pulse", cnt_ovf, 1);
        expect_eq("after_reset_car_entered", cnt_ce, 2);
        expect_eq("after_reset_barrier", cnt_bar, 3);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
